// File: rtl/mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_pipe
// Brief    : Two-stage pipelined multiply-accumulate. Stage 1 registers the
//            full-width product; stage 2 adds it into a signed/unsigned,
//            saturating or wrapping accumulator with sticky overflow and a
//            saturating term counter.
// Revision : 1.0 - initial release
// ============================================================================
module mac_pipe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [ACC_WIDTH-1:0] accumulator,
  output logic                 acc_valid,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int PW = 2 * WIDTH;

  // The product must fit in the accumulator without truncation.
  if (ACC_WIDTH < PW) begin : g_width_check
    $error("mac_pipe: ACC_WIDTH must be >= 2*WIDTH");
  end

  logic                 s1_valid;
  logic                 s1_clr;
  logic [PW-1:0]        s1_prod;

  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] sat_val;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] next_acc;

  // Multiplier and accumulator arithmetic, specialised per signedness.
  if (SIGNED != 0) begin : g_signed
    assign prod     = PW'($signed(A)) * PW'($signed(B));
    assign prod_ext = ACC_WIDTH'($signed(s1_prod));
    assign sum      = accumulator + prod_ext;
    // Overflow only possible when both addends share a sign.
    assign ovf      = (accumulator[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != accumulator[ACC_WIDTH-1]);
    // Clamp toward the direction the addends were heading.
    assign sat_val  = accumulator[ACC_WIDTH-1] ?
                      {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                      {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end else begin : g_unsigned
    logic carry;
    assign prod             = PW'(A) * PW'(B);
    assign prod_ext         = ACC_WIDTH'(s1_prod);
    assign {carry, sum}     = {1'b0, accumulator} + {1'b0, prod_ext};
    assign ovf              = carry;
    assign sat_val          = {ACC_WIDTH{1'b1}};
  end

  if (SATURATE != 0) begin : g_saturate
    assign next_acc = ovf ? sat_val : sum;
  end else begin : g_wrap
    assign next_acc = sum;
  end

  // Product register plus accumulate/clear/hold update of the running sum.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s1_clr      <= 1'b0;
      s1_prod     <= '0;
      accumulator <= '0;
      acc_valid   <= 1'b0;
      overflow    <= 1'b0;
      count       <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_clr    <= clear;
      s1_prod   <= prod;
      acc_valid <= s1_valid | s1_clr;
      if (s1_valid && s1_clr) begin
        accumulator <= prod_ext;
        count       <= CNT_WIDTH'(1);
        overflow    <= 1'b0;
      end else if (s1_valid) begin
        accumulator <= next_acc;
        overflow    <= overflow | ovf;
        if (count != {CNT_WIDTH{1'b1}}) begin
          count <= count + CNT_WIDTH'(1);
        end
      end else if (s1_clr) begin
        accumulator <= '0;
        count       <= '0;
        overflow    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_pipe
// Brief    : Scoreboarded directed bench for mac_pipe. Three instances cover
//            unsigned-wrap, unsigned-saturate and signed-wrap configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_pipe;

  typedef struct {
    int          dut;
    logic [15:0] acc;
    int          cnt;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        vld [3];
  logic        clr [3];
  logic [15:0] acc [3];
  logic        av  [3];
  logic        ov  [3];
  logic [7:0]  cnt [3];

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0), .CNT_WIDTH(8)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(vld[0]), .clear(clr[0]), .A(a), .B(b),
    .accumulator(acc[0]), .acc_valid(av[0]), .overflow(ov[0]), .count(cnt[0]));

  mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1), .CNT_WIDTH(8)) u_sat (
    .clk(clk), .reset(reset), .in_valid(vld[1]), .clear(clr[1]), .A(a), .B(b),
    .accumulator(acc[1]), .acc_valid(av[1]), .overflow(ov[1]), .count(cnt[1]));

  mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0), .CNT_WIDTH(8)) u_sgn (
    .clk(clk), .reset(reset), .in_valid(vld[2]), .clear(clr[2]), .A(a), .B(b),
    .accumulator(acc[2]), .acc_valid(av[2]), .overflow(ov[2]), .count(cnt[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus to instance d; others stay idle.
  task automatic step(input int d, input bit v, input bit c,
                      input logic [7:0] av_i, input logic [7:0] bv_i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vld[i] = (i == d) ? v : 1'b0;
      clr[i] = (i == d) ? c : 1'b0;
    end
    a = av_i;
    b = bv_i;
  endtask

  task automatic expect_out(input int d, input logic [15:0] e_acc,
                            input int e_cnt, input logic e_ovf);
    exp_t e;
    e.dut = d; e.acc = e_acc; e.cnt = e_cnt; e.ovf = e_ovf; e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      clr[i] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  // Scoreboard consumer: every acc_valid pulse must match the oldest entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (av[i] === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_acc_valid", i, 99);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dut_id", i, e.dut);
          check("acc", acc[i], e.acc);
          check("count", cnt[i], e.cnt);
          check("overflow", ov[i], e.ovf);
          check("latency", cyc, e.due);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    a = '0;
    b = '0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      clr[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_acc", acc[i], 0);
      check("rst_cnt", cnt[i], 0);
      check("rst_ovf", ov[i], 0);
      check("rst_valid", av[i], 0);
    end

    // Short unsigned stream with leading clear.
    step(0, 1, 1, 8'd13, 8'd4);   expect_out(0, 16'd52, 1, 1'b0);
    step(0, 1, 0, 8'd7,  8'd3);   expect_out(0, 16'd73, 2, 1'b0);
    step(0, 1, 0, 8'd3,  8'd6);   expect_out(0, 16'd91, 3, 1'b0);
    idle();
    drain();

    // Large products, then a clear bubble.
    step(0, 1, 1, 8'd201, 8'd130); expect_out(0, 16'd26130, 1, 1'b0);
    step(0, 1, 0, 8'd14,  8'd2);   expect_out(0, 16'd26158, 2, 1'b0);
    step(0, 0, 1, 8'd0,   8'd0);   expect_out(0, 16'd0, 0, 1'b0);
    idle();
    drain();
    check("hold_acc", acc[0], 0);

    // Wrapping overflow, then a clear drops the sticky flag.
    step(0, 1, 1, 8'd255, 8'd255); expect_out(0, 16'd65025, 1, 1'b0);
    step(0, 1, 0, 8'd255, 8'd255); expect_out(0, 16'd64514, 2, 1'b1);
    step(0, 1, 1, 8'd1,   8'd1);   expect_out(0, 16'd1, 1, 1'b0);
    idle();
    drain();

    // Saturating overflow pins the sum at all-ones.
    step(1, 1, 1, 8'd255, 8'd255); expect_out(1, 16'd65025, 1, 1'b0);
    step(1, 1, 0, 8'd255, 8'd255); expect_out(1, 16'd65535, 2, 1'b1);
    step(1, 1, 0, 8'd2,   8'd2);   expect_out(1, 16'd65535, 3, 1'b1);
    idle();
    drain();

    // Term counter stops at all-ones.
    for (int n = 1; n <= 300; n++) begin
      step(0, 1, n == 1, 8'd1, 8'd1);
      expect_out(0, 16'(n), (n > 255) ? 255 : n, 1'b0);
    end
    idle();
    drain();

    // Signed accumulation.
    step(2, 1, 1, 8'hFD, 8'd5);   expect_out(2, 16'hFFF1, 1, 1'b0);
    step(2, 1, 0, 8'd4,  8'd2);   expect_out(2, 16'hFFF9, 2, 1'b0);
    idle();
    drain();

    // Reset the cycle after a product is sampled: it must be lost.
    step(2, 1, 0, 8'd4, 8'd2);
    @(negedge clk);
    vld[2] = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_acc", acc[2], 0);
    check("midrst_cnt", cnt[2], 0);
    check("midrst_ovf", ov[2], 0);
    check("midrst_other", acc[0], 0);

    // Accumulation resumes from zero without a clear.
    step(2, 1, 0, 8'd3, 8'd3);    expect_out(2, 16'd9, 1, 1'b0);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
Parametrised, two-stage pipelined multiply-accumulate unit; successor to the 8-bit single-cycle MAC in the mac library.
- Adds configurable operand and accumulator widths, a signed/unsigned mode, and saturating or wrapping accumulation.
- Adds a valid qualifier, an in-band clear (start new sum), a sticky overflow flag and an accumulated-term counter.
- Sits between operand sources (FIR/dot-product datapaths) and downstream result consumers.

Parameters:
WIDTH, 8, operand width in bits (A and B).
ACC_WIDTH, 16, accumulator width; must be >= 2*WIDTH (elaboration error otherwise).
SIGNED, 0, 1 = two's-complement operands and accumulator; 0 = unsigned.
SATURATE, 0, 1 = clamp accumulator on overflow; 0 = wrap modulo 2^ACC_WIDTH.
CNT_WIDTH, 8, width of the term counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
in_valid  input  1  A/B/clear are sampled when high.
clear  input  1  with in_valid: accumulator restarts at this product; without in_valid: accumulator zeroed.
A  input  WIDTH  multiplicand.
B  input  WIDTH  multiplier.
accumulator  output  ACC_WIDTH  running sum.
acc_valid  output  1  one-cycle pulse: accumulator just updated by a product or clear.
overflow  output  1  sticky: some accumulate since the last clear overflowed.
count  output  CNT_WIDTH  products accumulated since the last clear; saturates at all-ones.

Behaviour:
- Reset (reset=0 at a rising edge):
  - accumulator=0, acc_valid=0, overflow=0, count=0.
  - Stage-1 valid/clear flags cleared; in-flight product discarded.
  - Reset overrides in_valid and clear.
- Stage 1, every edge:
  - s1_valid <= in_valid.
  - s1_clr <= clear.
  - s1_prod <= A*B, full 2*WIDTH bits, signed or unsigned per SIGNED.
  - A clear with in_valid=0 is still registered as a clear bubble.
- Stage 2:
  - If s1_valid=1 and s1_clr=1: accumulator <= ext(s1_prod), count <= 1, overflow <= 0.
  - If s1_valid=1 and s1_clr=0: accumulator <= accumulator + ext(s1_prod), count <= count+1 (held at all-ones), overflow <= overflow | ovf.
  - If s1_valid=0 and s1_clr=1: accumulator <= 0, count <= 0, overflow <= 0.
  - Otherwise: all hold.
  - ext() is sign-extension when SIGNED=1, zero-extension otherwise.
- Overflow detection (ovf):
  - Unsigned: carry out of ACC_WIDTH.
  - Signed: operands of equal sign, result sign differs.
- SATURATE=1 on ovf:
  - Unsigned: accumulator = 2^ACC_WIDTH-1.
  - Signed: max positive or min negative, per operand sign.
- SATURATE=0 on ovf: the wrapped sum is stored; overflow is still set.
- acc_valid <= s1_valid | s1_clr. It is high exactly in the cycle the new accumulator value is first visible.
- Latency: operands sampled at edge k are reflected in accumulator after edge k+1. Full throughput, one product per cycle, no backpressure.
- Back-to-back valid cycles accumulate in order. A clear in the middle of a stream affects only its own product and later ones.
- Reset mid-stream: every product sampled at or before the reset edge is lost. Accumulation resumes from 0 with inputs sampled after reset is released.

Test Plan:
1. Defaults. Hold reset=0 for 2 edges, then release with in_valid=0 -> accumulator=0, count=0, overflow=0, acc_valid=0.
2. Defaults. Issue 13x4 with clear=1, then 7x3, then 3x6, on consecutive cycles -> accumulator 52, 73, 91 on successive cycles; count 1, 2, 3; acc_valid high 3 cycles; first update two edges after first sample.
3. Defaults. Issue 201x130 with clear=1, then 14x2 -> 26130, then 26158. Then pulse clear with in_valid=0 -> accumulator=0, count=0, acc_valid one pulse.
4. SATURATE=0. Issue 255x255 with clear=1, then 255x255 -> accumulator 65025, then 64514 (wrapped), overflow=1. The next clear-accumulate of 1x1 -> accumulator=1, overflow=0.
5. SATURATE=1. Same stimulus as scenario 4 -> second result 65535, overflow=1. A further 2x2 keeps 65535.
6. SIGNED=1. Issue (-3)x5 with clear=1, then 4x2 -> 0xFFF1, then 0xFFF9 (-7). Assert reset=0 on the cycle after 4x2 is sampled -> accumulator=0; the product is never accumulated.
